// File: rtl/keypad_entry_ctrl.sv
// PS/2 keypad entry controller: collects up to four BCD digits from scancodes
// and commits them on Enter. Backspace, break-code skipping and idle timeout are included.
module keypad_entry_ctrl #(
    parameter int unsigned TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [7:0]  code,
    input  logic        code_valid,
    output logic [15:0] digits,
    output logic [2:0]  count,
    output logic [15:0] value,
    output logic [2:0]  value_len,
    output logic        done,
    output logic        err
);

    localparam logic [7:0]  CodeBreak = 8'hF0;
    localparam logic [7:0]  CodeBksp  = 8'h66;
    localparam logic [7:0]  CodeEnter = 8'h5A;
    localparam logic [15:0] IdleMax   = 16'(TIMEOUT - 1);

    typedef enum logic [0:0] {StAccept, StBreak} state_e;

    state_e      state;
    logic [15:0] idle_cnt;
    logic        is_digit;
    logic [3:0]  digit_val;

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (code)
            8'h45:   digit_val = 4'd0;
            8'h16:   digit_val = 4'd1;
            8'h1E:   digit_val = 4'd2;
            8'h26:   digit_val = 4'd3;
            8'h25:   digit_val = 4'd4;
            8'h2E:   digit_val = 4'd5;
            8'h36:   digit_val = 4'd6;
            8'h3D:   digit_val = 4'd7;
            8'h3E:   digit_val = 4'd8;
            8'h46:   digit_val = 4'd9;
            default: is_digit  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= StAccept;
            digits    <= '0;
            count     <= '0;
            value     <= '0;
            value_len <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (code_valid) begin
                idle_cnt <= '0;
                // E0 and any unlisted byte fall through every branch untouched.
                if (state == StBreak) begin
                    state <= StAccept;
                end else if (code == CodeBreak) begin
                    state <= StBreak;
                end else if (is_digit) begin
                    if (count < 3'd4) begin
                        digits <= {digits[11:0], digit_val};
                        count  <= count + 3'd1;
                    end else begin
                        err <= 1'b1;
                    end
                end else if (code == CodeBksp) begin
                    if (count != 3'd0) begin
                        digits <= {4'h0, digits[15:4]};
                        count  <= count - 3'd1;
                    end
                end else if (code == CodeEnter) begin
                    if (count != 3'd0) begin
                        value     <= digits;
                        value_len <= count;
                        done      <= 1'b1;
                        digits    <= '0;
                        count     <= '0;
                    end else begin
                        err <= 1'b1;
                    end
                end
            end else if (count == 3'd0) begin
                idle_cnt <= '0;
            end else if (idle_cnt == IdleMax) begin
                // Abandon the partial entry; BREAK/ACCEPT state is left as is.
                digits   <= '0;
                count    <= '0;
                err      <= 1'b1;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with TIMEOUT=8; each task checks its own scenario.
module tb_keypad_entry_ctrl;

    logic        clk;
    logic        areset;
    logic [7:0]  code;
    logic        code_valid;
    logic [15:0] digits;
    logic [2:0]  count;
    logic [15:0] value;
    logic [2:0]  value_len;
    logic        done;
    logic        err;

    int n_cmp;
    int n_bad;
    int done_cnt;
    int err_cnt;

    keypad_entry_ctrl #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .code       (code),
        .code_valid (code_valid),
        .digits     (digits),
        .count      (count),
        .value      (value),
        .value_len  (value_len),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One byte per cycle; returns 1 time unit after the sampling edge.
    task automatic send(input logic [7:0] b);
        code       = b;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        code       = 8'h00;
        if (done) done_cnt++;
        if (err)  err_cnt++;
    endtask

    // Idle cycles carry a digit code with code_valid low, which must be ignored.
    task automatic idle(input int n);
        code_valid = 1'b0;
        code       = 8'h16;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
            if (err)  err_cnt++;
        end
        code = 8'h00;
    endtask

    task automatic test_reset;
        n_cmp++;
        if ({digits, count, value, value_len, done, err} !== 40'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", {digits, count, value, value_len, done, err});
        end
    endtask

    task automatic test_break_codes;
        done_cnt = 0; err_cnt = 0;
        send(8'h16); send(8'hF0); send(8'h16); send(8'h1E); send(8'hF0);
        send(8'h1E); send(8'h5A);
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL brk_done_on_enter: got %b want 1", done);
        end
        send(8'hF0); send(8'h5A);
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++; $display("FAIL brk_done_count: got %0d want 1", done_cnt);
        end
        n_cmp++;
        if (err_cnt !== 0) begin
            n_bad++; $display("FAIL brk_err_count: got %0d want 0", err_cnt);
        end
        n_cmp++;
        if (value !== 16'h0012 || value_len !== 3'd2) begin
            n_bad++; $display("FAIL brk_value: got %h/%0d want 0012/2", value, value_len);
        end
        n_cmp++;
        if (count !== 3'd0 || digits !== 16'h0000) begin
            n_bad++; $display("FAIL brk_cleared: got %h/%0d want 0000/0", digits, count);
        end
    endtask

    task automatic test_overflow;
        done_cnt = 0; err_cnt = 0;
        send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
        n_cmp++;
        if (err_cnt !== 0 || digits !== 16'h1234 || count !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_fill: got err=%0d %h/%0d want 0 1234/4", err_cnt, digits, count);
        end
        send(8'h2E);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0) begin
            n_bad++; $display("FAIL ovf_err_pulse: got err=%b done=%b want 1 0", err, done);
        end
        n_cmp++;
        if (digits !== 16'h1234 || count !== 3'd4) begin
            n_bad++; $display("FAIL ovf_buffer_held: got %h/%0d want 1234/4", digits, count);
        end
        send(8'h5A);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b0 || value !== 16'h1234 || value_len !== 3'd4) begin
            n_bad++;
            $display("FAIL ovf_commit: got d=%b e=%b %h/%0d want 1 0 1234/4",
                     done, err, value, value_len);
        end
    endtask

    task automatic test_backspace;
        done_cnt = 0; err_cnt = 0;
        send(8'h66);
        n_cmp++;
        if (err !== 1'b0 || count !== 3'd0) begin
            n_bad++; $display("FAIL bs_empty: got err=%b count=%0d want 0 0", err, count);
        end
        send(8'h26); send(8'h25); send(8'h66);
        n_cmp++;
        if (digits !== 16'h0003 || count !== 3'd1) begin
            n_bad++; $display("FAIL bs_shift: got %h/%0d want 0003/1", digits, count);
        end
        send(8'h1C);
        n_cmp++;
        if (digits !== 16'h0003 || count !== 3'd1 || err !== 1'b0) begin
            n_bad++; $display("FAIL other_byte: got %h/%0d err=%b want 0003/1 0", digits, count, err);
        end
        send(8'h2E); send(8'h5A);
        n_cmp++;
        if (done !== 1'b1 || value !== 16'h0035 || value_len !== 3'd2) begin
            n_bad++; $display("FAIL bs_commit: got d=%b %h/%0d want 1 0035/2", done, value, value_len);
        end
        send(8'h5A);
        n_cmp++;
        if (err !== 1'b1 || done !== 1'b0 || value !== 16'h0035 || value_len !== 3'd2) begin
            n_bad++;
            $display("FAIL empty_enter: got e=%b d=%b %h/%0d want 1 0 0035/2",
                     err, done, value, value_len);
        end
    endtask

    task automatic test_timeout;
        done_cnt = 0; err_cnt = 0;
        send(8'h46);
        idle(7);
        n_cmp++;
        if (err_cnt !== 0 || count !== 3'd1 || digits !== 16'h0009) begin
            n_bad++;
            $display("FAIL to_before: got err=%0d %h/%0d want 0 0009/1", err_cnt, digits, count);
        end
        idle(1);
        n_cmp++;
        if (err !== 1'b1 || count !== 3'd0 || digits !== 16'h0000) begin
            n_bad++; $display("FAIL to_fire: got e=%b %h/%0d want 1 0000/0", err, digits, count);
        end
        idle(1);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++; $display("FAIL to_one_cycle: got err=%b want 0", err);
        end
        err_cnt = 0;
        send(8'h46); idle(7); send(8'h16);
        n_cmp++;
        if (err_cnt !== 0 || digits !== 16'h0091 || count !== 3'd2) begin
            n_bad++;
            $display("FAIL to_seven_idle: got err=%0d %h/%0d want 0 0091/2", err_cnt, digits, count);
        end
        send(8'h5A);
        n_cmp++;
        if (done !== 1'b1 || value !== 16'h0091 || value_len !== 3'd2) begin
            n_bad++; $display("FAIL to_commit: got d=%b %h/%0d want 1 0091/2", done, value, value_len);
        end
    endtask

    task automatic test_f0_e0;
        send(8'hF0); send(8'hF0); send(8'h16);
        n_cmp++;
        if (count !== 3'd1 || digits !== 16'h0001) begin
            n_bad++; $display("FAIL double_f0: got %h/%0d want 0001/1", digits, count);
        end
        send(8'hE0);
        n_cmp++;
        if (count !== 3'd1 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL e0_noop: got count=%0d d=%b e=%b want 1 0 0", count, done, err);
        end
        send(8'h5A);
        n_cmp++;
        if (done !== 1'b1 || value !== 16'h0001 || value_len !== 3'd1) begin
            n_bad++; $display("FAIL e0_enter: got d=%b %h/%0d want 1 0001/1", done, value, value_len);
        end
    endtask

    task automatic test_reset_mid;
        send(8'h16); send(8'h1E); send(8'h26);
        #2 areset = 1'b1;
        #1;
        n_cmp++;
        if ({digits, count, value, value_len, done, err} !== 40'd0) begin
            n_bad++;
            $display("FAIL rst_mid_entry: got %h want 0", {digits, count, value, value_len, done, err});
        end
        #1 areset = 1'b0;
        send(8'h45);
        n_cmp++;
        if (count !== 3'd1 || digits !== 16'h0000) begin
            n_bad++; $display("FAIL rst_resume: got %h/%0d want 0000/1", digits, count);
        end
        send(8'hF0);
        #2 areset = 1'b1;
        #1;
        n_cmp++;
        if (count !== 3'd0 || done !== 1'b0 || err !== 1'b0) begin
            n_bad++; $display("FAIL rst_in_break: got count=%0d d=%b e=%b want 0", count, done, err);
        end
        #1 areset = 1'b0;
        send(8'h45);
        n_cmp++;
        if (count !== 3'd1 || digits !== 16'h0000) begin
            n_bad++; $display("FAIL rst_break_cleared: got %h/%0d want 0000/1", digits, count);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        done_cnt   = 0;
        err_cnt    = 0;
        areset     = 1'b1;
        code       = 8'h00;
        code_valid = 1'b0;
        #12;
        test_reset;
        #1 areset = 1'b0;
        @(posedge clk);
        #1;
        test_break_codes;
        test_overflow;
        test_backspace;
        test_timeout;
        test_f0_e0;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1000: idle cycles after which a partial entry is abandoned; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port areset  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port code  input  8  PS/2 scancode byte.
REQ-005 SHALL have port code_valid  input  1  code is presented this cycle; one byte per cycle.
REQ-006 SHALL have port digits  output  16  live entry buffer, four BCD nibbles; newest digit in [3:0].
REQ-007 SHALL have port count  output  3  number of digits currently in the buffer, 0..4.
REQ-008 SHALL have port value  output  16  last committed entry, BCD, same layout as digits.
REQ-009 SHALL have port value_len  output  3  digit count of the last committed entry, 1..4.
REQ-010 SHALL have port done  output  1  one-cycle pulse: value/value_len updated.
REQ-011 SHALL have port err  output  1  one-cycle pulse: overflow, empty enter or timeout.

Function
REQ-012 SHALL register all outputs; the effect of a byte sampled at edge N is visible after edge N.
REQ-013 SHALL map make codes 45,16,1E,26,25,2E,36,3D,3E,46 (hex) to digits 0..9 respectively.
REQ-014 SHALL implement FSM states ACCEPT and BREAK; reset state is ACCEPT.
REQ-015 SHALL, in ACCEPT with F0 valid, move to BREAK with no other effect.
REQ-016 SHALL, in BREAK, consume the next valid byte of any value (including F0, E0, 5A) with no effect and return to ACCEPT.
REQ-017 SHALL, in ACCEPT, treat E0 as a no-op that does not change state; the following byte is decoded normally.
REQ-018 SHALL, in ACCEPT on a digit with count<4, shift digits left by 4 bits, insert the digit at [3:0], and increment count.
REQ-019 SHALL, in ACCEPT on a digit with count==4, drop the digit, leave the buffer unchanged, and pulse err.
REQ-020 SHALL, in ACCEPT on 66 (backspace) with count>0, shift digits right by 4 bits with zero fill at [15:12] and decrement count; with count==0, do nothing and not pulse err.
REQ-021 SHALL, in ACCEPT on 5A (enter) with count>0: load value<=digits and value_len<=count; pulse done; clear digits and count in the same edge.
REQ-022 SHALL, in ACCEPT on 5A with count==0, pulse err, not pulse done, and leave value unchanged.
REQ-023 SHALL ignore all other bytes in ACCEPT (no state, buffer or pulse change).
REQ-024 SHALL hold an idle counter that resets to 0 on any code_valid cycle, and also whenever count==0.
REQ-025 SHALL, when count>0 and TIMEOUT consecutive cycles pass without code_valid, clear digits and count, pulse err, and reset the idle counter; the FSM state is unchanged.
REQ-026 SHALL never assert done and err in the same cycle, and each SHALL stay high for exactly one cycle per event.
REQ-027 SHALL ignore code contents whenever code_valid is low.

Reset
REQ-028 SHALL, while areset is high, immediately force the state to ACCEPT and clear digits, count, value, value_len, done, err and the idle counter to 0, regardless of clk.
REQ-029 SHALL discard a partial entry or pending BREAK when reset is asserted mid-operation, and resume decoding from the first edge after deassertion.

Verification
REQ-030 SHALL cover: bytes 16,F0,16,1E,F0,1E,5A,F0,5A -> done pulses once, value=0x0012, value_len=2, count=0 afterwards.
REQ-031 SHALL cover: digits 1,2,3,4,5 then 5A -> err on the fifth digit, then done with value=0x1234, value_len=4.
REQ-032 SHALL cover: 26,25,66,2E,5A -> digits=0x0003 after 66, then value=0x0035, value_len=2; also 5A with empty buffer -> err, no done, value unchanged.
REQ-033 SHALL cover, with TIMEOUT=8: 46, then 8 idle cycles -> err one cycle after the 8th idle cycle, count=0; with only 7 idle cycles before the next byte -> no err.
REQ-034 SHALL cover: F0 then F0 then 16 -> second F0 skipped, 16 accepted, count=1; E0,5A with count=1 -> done.
REQ-035 SHALL cover: areset pulsed between clock edges during a 3-digit entry and in BREAK -> all outputs 0 immediately, and the next 45 is accepted as digit 0.
